// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler: FSM encoding,
// default data width and the watchdog counter sizing helper.
package cordic_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Width of a counter that must reach timeout_cyc-1.
   function automatic int wd_width(input int timeout_cyc);
      return (timeout_cyc <= 2) ? 1 : $clog2(timeout_cyc);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after ptr, searching circularly.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);

   // Circular priority search starting at ptr.
   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      int s;
      logic [ID_W-1:0] idx;
      grant    = '0;
      grant_id = '0;
      any      = 1'b0;
      s        = 0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         s = int'(ptr) + i;
         if (s >= NUM_REQ) s = s - NUM_REQ;
         idx = ID_W'(s);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one iterative CORDIC core among NUM_REQ requesters: round-robin
// accept, one-cycle start pulse, watchdog-guarded wait for done, and a
// held response tagged with the requester id.
module cordic_req_scheduler
   import cordic_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_theta,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_sine,
   output logic [DATA_W-1:0]         rsp_cosine,
   output logic                      rsp_error,
   output logic                      core_start,
   output logic [DATA_W-1:0]         core_theta,
   input  logic                      core_done,
   input  logic [DATA_W-1:0]         core_sine,
   input  logic [DATA_W-1:0]         core_cosine,
   output logic                      busy
);

   localparam int WD_W = wd_width(TIMEOUT_CYC);

   state_t              state, state_next;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     ptr_next;
   logic [ID_W-1:0]     grant_id;
   logic [NUM_REQ-1:0]  grant;
   logic                grant_any;
   logic [DATA_W-1:0]   grant_theta;
   logic [WD_W-1:0]     watchdog;
   logic                wd_hit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req      (req_valid),
      .ptr      (rr_ptr),
      .grant    (grant),
      .grant_id (grant_id),
      .any      (grant_any)
   );

   assign ptr_next    = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
   assign grant_theta = req_theta[int'(grant_id)*DATA_W +: DATA_W];
   assign wd_hit      = (watchdog == WD_W'(TIMEOUT_CYC-1));

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state and handshake outputs; core_done is only honoured in BUSY,
   // and it wins over the watchdog when both occur together.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (grant_any) begin
               req_ready  = grant;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_start = 1'b1;
            state_next = ST_BUSY;
         end
         ST_BUSY: begin
            if (core_done || wd_hit) state_next = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Job datapath: accept latch, round-robin pointer, watchdog and result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr     <= '0;
         core_theta <= '0;
         rsp_id     <= '0;
         rsp_sine   <= '0;
         rsp_cosine <= '0;
         rsp_error  <= 1'b0;
         watchdog   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_any) begin
                  rr_ptr     <= ptr_next;
                  core_theta <= grant_theta;
                  rsp_id     <= grant_id;
               end
            end
            ST_ISSUE: watchdog <= '0;
            ST_BUSY: begin
               watchdog <= watchdog + WD_W'(1);
               if (core_done) begin
                  rsp_sine   <= core_sine;
                  rsp_cosine <= core_cosine;
                  rsp_error  <= 1'b0;
               end else if (wd_hit) begin
                  rsp_sine   <= '0;
                  rsp_cosine <= '0;
                  rsp_error  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Directed testbench for cordic_req_scheduler with a behavioural core model
// of programmable latency (sine = theta ^ 16'hA5A5, cosine = ~theta).
module tb_cordic_req_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_theta;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_sine;
   logic [15:0] rsp_cosine;
   logic        rsp_error;
   logic        core_start;
   logic [15:0] core_theta;
   logic        core_done;
   logic [15:0] core_sine;
   logic [15:0] core_cosine;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   // Core model controls
   int          core_lat  = 16;
   bit          core_hang = 1'b0;
   bit          spurious  = 1'b0;
   bit          pend      = 1'b0;
   int          cnt       = 0;
   logic [15:0] mtheta    = '0;

   cordic_req_scheduler #(
      .NUM_REQ(4), .ID_W(2), .DATA_W(16), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_theta(req_theta), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sine(rsp_sine), .rsp_cosine(rsp_cosine), .rsp_error(rsp_error),
      .core_start(core_start), .core_theta(core_theta), .core_done(core_done),
      .core_sine(core_sine), .core_cosine(core_cosine), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_sine(input logic [15:0] t);
      return t ^ 16'hA5A5;
   endfunction

   function automatic logic [15:0] exp_cos(input logic [15:0] t);
      return ~t;
   endfunction

   // Core model: done is high during cycle start+core_lat.
   initial begin
      core_done   = 1'b0;
      core_sine   = '0;
      core_cosine = '0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (spurious) begin
            core_done   = 1'b1;
            core_sine   = 16'hDEAD;
            core_cosine = 16'hBEEF;
            spurious    = 1'b0;
         end
         if (pend) begin
            if (cnt <= 1) begin
               core_done   = 1'b1;
               core_sine   = exp_sine(mtheta);
               core_cosine = exp_cos(mtheta);
               pend        = 1'b0;
            end else begin
               cnt = cnt - 1;
            end
         end
         if (core_start === 1'b1) begin
            pend   = !core_hang;
            cnt    = core_lat;
            mtheta = core_theta;
         end
      end
   end

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b1;
      core_hang = 1'b0;
      spurious  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pend  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain_timeout: busy still 1 after %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = '0;
      req_theta = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({busy, core_start, rsp_valid, rsp_error, req_ready, rsp_id, rsp_sine, rsp_cosine, core_theta} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b start=%b rv=%b err=%b rdy=%b id=%0d s=%h c=%h th=%h, want all 0",
                  busy, core_start, rsp_valid, rsp_error, req_ready, rsp_id, rsp_sine, rsp_cosine, core_theta);
      end
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_single();
      int n;
      logic [15:0] th = 16'h2000;
      do_reset();
      core_lat = 16;
      @(negedge clk);
      req_theta = '0;
      req_theta[2*16 +: 16] = th;
      req_valid = 4'b0100;
      #1;
      tests_run++;
      if (req_ready !== 4'b0100) begin
         tests_failed++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      tests_run++;
      if (core_start !== 1'b1 || core_theta !== th) begin
         tests_failed++;
         $display("FAIL single_start: start=%b theta=%h want 1 %h", core_start, core_theta, th);
      end
      n = 1;
      while (rsp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n != 18) begin
         tests_failed++;
         $display("FAIL single_latency: rsp_valid at T+%0d want T+18", n);
      end
      tests_run++;
      if (rsp_id !== 2'd2 || rsp_sine !== exp_sine(th) || rsp_cosine !== exp_cos(th) || rsp_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_data: id=%0d s=%h c=%h err=%b want 2 %h %h 0",
                  rsp_id, rsp_sine, rsp_cosine, rsp_error, exp_sine(th), exp_cos(th));
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_fairness();
      int cnt_grant[4] = '{0, 0, 0, 0};
      int n;
      int want;
      do_reset();
      core_lat = 3;
      @(negedge clk);
      for (int k = 0; k < 4; k++) req_theta[k*16 +: 16] = 16'h1000 * (k + 1) + 16'h0011;
      req_valid = 4'hF;
      for (int j = 0; j < 8; j++) begin
         want = j % 4;
         n = 0;
         #1;
         while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
         end
         tests_run++;
         if (req_ready !== 4'(1 << want)) begin
            tests_failed++;
            $display("FAIL fair_grant%0d: got %b want grant %0d", j, req_ready, want);
         end
         for (int b = 0; b < 4; b++) if (req_ready[b] === 1'b1) cnt_grant[b]++;
         @(negedge clk);
         tests_run++;
         if (core_theta !== 16'(16'h1000 * (want + 1) + 16'h0011)) begin
            tests_failed++;
            $display("FAIL fair_theta%0d: got %h want %h", j, core_theta, 16'(16'h1000 * (want + 1) + 16'h0011));
         end
      end
      req_valid = '0;
      drain();
      for (int b = 0; b < 4; b++) begin
         tests_run++;
         if (cnt_grant[b] != 2) begin
            tests_failed++;
            $display("FAIL fair_count%0d: accepted %0d times want 2", b, cnt_grant[b]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      logic [1:0]  s_id;
      logic [15:0] s_sin, s_cos;
      logic        s_err;
      do_reset();
      core_lat  = 4;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_theta[1*16 +: 16] = 16'h4321;
      req_valid = 4'b0010;
      while (rsp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sine !== exp_sine(16'h4321)) begin
         tests_failed++;
         $display("FAIL bp_first: rv=%b id=%0d s=%h want 1 1 %h", rsp_valid, rsp_id, rsp_sine, exp_sine(16'h4321));
      end
      s_id = rsp_id; s_sin = rsp_sine; s_cos = rsp_cosine; s_err = rsp_error;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests_run++;
         if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_sine !== s_sin || rsp_cosine !== s_cos ||
             rsp_error !== s_err || req_ready !== 4'b0000 || core_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold%0d: rv=%b id=%0d s=%h c=%h err=%b rdy=%b start=%b want held response, no accept/start",
                     c, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_error, req_ready, core_start);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || req_ready !== 4'b0010) begin
         tests_failed++;
         $display("FAIL bp_release: busy=%b rdy=%b want 0 0010", busy, req_ready);
      end
      req_valid = '0;
   endtask

   task automatic test_timeout();
      int n = 0;
      do_reset();
      core_hang = 1'b1;
      @(negedge clk);
      req_theta[0 +: 16] = 16'h7FFF;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      tests_run++;
      if (core_start !== 1'b1) begin
         tests_failed++;
         $display("FAIL to_start: start=%b want 1", core_start);
      end
      while (rsp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n != 65) begin
         tests_failed++;
         $display("FAIL to_latency: rsp_valid %0d cycles after start want 65", n);
      end
      tests_run++;
      if (rsp_error !== 1'b1 || rsp_sine !== 16'h0 || rsp_cosine !== 16'h0 || rsp_id !== 2'd0) begin
         tests_failed++;
         $display("FAIL to_data: err=%b s=%h c=%h id=%0d want 1 0 0 0", rsp_error, rsp_sine, rsp_cosine, rsp_id);
      end
      @(negedge clk);
      core_hang = 1'b0;
      core_lat  = 5;
      req_theta[3*16 +: 16] = 16'h0123;
      req_valid = 4'b1000;
      n = 0;
      @(negedge clk);
      req_valid = '0;
      n = 1;
      while (rsp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n != 7 || rsp_error !== 1'b0 || rsp_id !== 2'd3 || rsp_sine !== exp_sine(16'h0123) || rsp_cosine !== exp_cos(16'h0123)) begin
         tests_failed++;
         $display("FAIL to_next_job: lat=%0d err=%b id=%0d s=%h c=%h want 7 0 3 %h %h",
                  n, rsp_error, rsp_id, rsp_sine, rsp_cosine, exp_sine(16'h0123), exp_cos(16'h0123));
      end
      drain();
   endtask

   task automatic test_reset_mid_busy();
      bit seen = 1'b0;
      do_reset();
      core_lat = 15;
      @(negedge clk);
      req_theta[1*16 +: 16] = 16'h1111;
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      tests_run++;
      if (core_start !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_start: start=%b want 1", core_start);
      end
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if ({busy, core_start, rsp_valid, rsp_error, req_ready, rsp_id, rsp_sine, rsp_cosine, core_theta} !== '0) begin
         tests_failed++;
         $display("FAIL rst_outputs: busy=%b start=%b rv=%b err=%b rdy=%b id=%0d s=%h c=%h th=%h want all 0",
                  busy, core_start, rsp_valid, rsp_error, req_ready, rsp_id, rsp_sine, rsp_cosine, core_theta);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_late_done: activity seen after reset, want none");
      end
      req_valid = 4'hF;
      #1;
      tests_run++;
      if (req_ready !== 4'b0001) begin
         tests_failed++;
         $display("FAIL rst_ptr: grant %b want 0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      drain();
   endtask

   task automatic test_race();
      int n = 0;
      bit bad = 1'b0;
      logic [15:0] th = 16'h0F0F;
      do_reset();
      core_lat = 64;
      @(negedge clk);
      req_theta[2*16 +: 16] = th;
      req_valid = 4'b0100;
      @(negedge clk);
      req_valid = '0;
      while (rsp_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n != 65 || rsp_error !== 1'b0 || rsp_sine !== exp_sine(th) || rsp_cosine !== exp_cos(th)) begin
         tests_failed++;
         $display("FAIL race_done_wins: lat=%0d err=%b s=%h c=%h want 65 0 %h %h",
                  n, rsp_error, rsp_sine, rsp_cosine, exp_sine(th), exp_cos(th));
      end
      drain();
      @(negedge clk);
      spurious = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (busy !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
      end
      tests_run++;
      if (bad !== 1'b0 || rsp_sine !== exp_sine(th) || rsp_cosine !== exp_cos(th)) begin
         tests_failed++;
         $display("FAIL spurious_done: activity=%b s=%h c=%h want 0 %h %h",
                  bad, rsp_sine, rsp_cosine, exp_sine(th), exp_cos(th));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_timeout();
      test_reset_mid_busy();
      test_race();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
